// File: rtl/melody_pkg.sv
// -----------------------------------------------------------------------------
// melody_pkg
//   Shared definitions for the melody sequencer slice:
//     - note indices NOTE_C4..NOTE_C5 (0..7), matching bit positions of the
//       one-hot note-select bus driven into the tone generator
//     - ROM field widths (NOTE_W, DUR_W, STEP_W) and the ROM word struct
//     - FSM state encodings (IDLE, PLAY, GAP)
//     - onehot8(): note index -> 8-bit one-hot select
// -----------------------------------------------------------------------------
package melody_pkg;

   localparam int NOTE_W = 3;
   localparam int DUR_W  = 2;
   localparam int STEP_W = 4;

   localparam logic [NOTE_W-1:0] NOTE_C4 = 3'd0;
   localparam logic [NOTE_W-1:0] NOTE_D4 = 3'd1;
   localparam logic [NOTE_W-1:0] NOTE_E4 = 3'd2;
   localparam logic [NOTE_W-1:0] NOTE_F4 = 3'd3;
   localparam logic [NOTE_W-1:0] NOTE_G4 = 3'd4;
   localparam logic [NOTE_W-1:0] NOTE_A4 = 3'd5;
   localparam logic [NOTE_W-1:0] NOTE_B4 = 3'd6;
   localparam logic [NOTE_W-1:0] NOTE_C5 = 3'd7;

   // FSM encodings kept as plain constants so older code can compare against them
   localparam int         STATE_W = 2;
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PLAY    = 2'd1;
   localparam logic [1:0] GAP     = 2'd2;

   // One ROM word: {rest, note, dur}; step length is (dur+1) beats
   typedef struct packed {
      logic              rest;
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
   } rom_entry_t;

   function automatic logic [7:0] onehot8(input logic [NOTE_W-1:0] n);
      onehot8 = 8'd1 << n;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// -----------------------------------------------------------------------------
// melody_rom
//   Combinational song table, 16 steps. Swapping songs only touches this file.
//   Ports:
//     step  in  [3:0]  ROM step index
//     rest  out        1 = silent step (timing still follows dur)
//     note  out [2:0]  note index, NOTE_C4..NOTE_C5
//     dur   out [1:0]  step length minus one, in beats
// -----------------------------------------------------------------------------
module melody_rom
   import melody_pkg::*;
(
   input  logic [STEP_W-1:0] step,
   output logic              rest,
   output logic [NOTE_W-1:0] note,
   output logic [DUR_W-1:0]  dur
);

   rom_entry_t entry;

   // Ascending scale, a held top C, one rest beat, then descending back to C4
   always_comb begin
      entry = '{rest: 1'b0, note: NOTE_C4, dur: 2'd0};
      case (step)
         4'd0:    entry = '{rest: 1'b0, note: NOTE_C4, dur: 2'd0};
         4'd1:    entry = '{rest: 1'b0, note: NOTE_D4, dur: 2'd0};
         4'd2:    entry = '{rest: 1'b0, note: NOTE_E4, dur: 2'd0};
         4'd3:    entry = '{rest: 1'b0, note: NOTE_F4, dur: 2'd0};
         4'd4:    entry = '{rest: 1'b0, note: NOTE_G4, dur: 2'd0};
         4'd5:    entry = '{rest: 1'b0, note: NOTE_A4, dur: 2'd0};
         4'd6:    entry = '{rest: 1'b0, note: NOTE_B4, dur: 2'd0};
         4'd7:    entry = '{rest: 1'b0, note: NOTE_C5, dur: 2'd1};
         4'd8:    entry = '{rest: 1'b1, note: NOTE_C4, dur: 2'd0};
         4'd9:    entry = '{rest: 1'b0, note: NOTE_B4, dur: 2'd0};
         4'd10:   entry = '{rest: 1'b0, note: NOTE_A4, dur: 2'd0};
         4'd11:   entry = '{rest: 1'b0, note: NOTE_G4, dur: 2'd0};
         4'd12:   entry = '{rest: 1'b0, note: NOTE_F4, dur: 2'd0};
         4'd13:   entry = '{rest: 1'b0, note: NOTE_E4, dur: 2'd0};
         4'd14:   entry = '{rest: 1'b0, note: NOTE_D4, dur: 2'd0};
         4'd15:   entry = '{rest: 1'b0, note: NOTE_C4, dur: 2'd0};
         default: entry = '{rest: 1'b0, note: NOTE_C4, dur: 2'd0};
      endcase
   end

   assign rest = entry.rest;
   assign note = entry.note;
   assign dur  = entry.dur;

endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//   Plays the 16-step song held in melody_rom and drives a one-hot note-select
//   bus in the same format as the board switches (bit k = note k, 0 = silence),
//   so it can feed the tone generator's sw input directly.
//
//   Each step plays its note for (dur+1)*beat - GAP_CYCLES cycles followed by
//   GAP_CYCLES of silence for articulation.
//
//   Optional build macro MELODY_SEQ_TEMPO_EN: adds input tempo[1:0]; the beat
//   becomes BEAT_CYCLES >> tempo, sampled on every PLAY entry. Gap unchanged.
//
//   Ports:
//     clk       in        rising-edge clock
//     rst_n     in        asynchronous active-low reset
//     start     in        level; starts the song from step 0 when idle
//     stop      in        level; aborts playback (wins over start)
//     loop_en   in        wrap to step 0 after the last step instead of finishing
//     tempo     in  [1:0] (MELODY_SEQ_TEMPO_EN only) speed-up shift
//     note_out  out [7:0] one-hot note select or 0, registered
//     step_idx  out [3:0] current ROM step, registered
//     busy      out       high in PLAY or GAP
//     done      out       one-cycle pulse when a non-looping song completes
// -----------------------------------------------------------------------------
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int BEAT_CYCLES = 2000,
   parameter int GAP_CYCLES  = 100,
   parameter int SONG_LEN    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
`ifdef MELODY_SEQ_TEMPO_EN
   input  logic [1:0] tempo,
`endif
   output logic [7:0] note_out,
   output logic [3:0] step_idx,
   output logic       busy,
   output logic       done
);

   // Longest step in this ROM is two beats; widen to 4*BEAT_CYCLES for dur=3 songs
   localparam int                 CNT_W     = $clog2(2 * BEAT_CYCLES);
   localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(SONG_LEN - 1);

   logic [STATE_W-1:0] state_reg,     state_next;
   logic [CNT_W-1:0]   cnt_reg,       cnt_next;
   logic [CNT_W-1:0]   play_last_reg, play_last_next;
   logic [STEP_W-1:0]  step_idx_reg,  step_idx_next;
   logic [7:0]         note_out_reg,  note_out_next;
   logic               done_reg,      done_next;

   logic [STEP_W-1:0]  rom_step;
   logic               rom_rest;
   logic [NOTE_W-1:0]  rom_note;
   logic [DUR_W-1:0]   rom_dur;

   logic               load_play;
   logic [CNT_W-1:0]   play_last_calc;
   int                 beat_cyc;
   int                 play_cyc;

   // ---------------------------------------------------------------------------
   // ROM is addressed with the step that the *next* PLAY entry will use, so the
   // note and its length are ready on the same edge that enters PLAY.
   // ---------------------------------------------------------------------------
   always_comb begin
      rom_step = '0;
      if (state_reg == GAP && step_idx_reg != LAST_STEP) begin
         rom_step = step_idx_reg + STEP_W'(1);
      end
   end

   melody_rom u_rom (
      .step (rom_step),
      .rest (rom_rest),
      .note (rom_note),
      .dur  (rom_dur)
   );

   // ---------------------------------------------------------------------------
   // Terminal count for the audible part of the upcoming step. Computed once at
   // PLAY entry, so a tempo change only affects the following step. Clamped to
   // one cycle so very fast tempos cannot underflow into a huge count.
   // ---------------------------------------------------------------------------
   always_comb begin
`ifdef MELODY_SEQ_TEMPO_EN
      beat_cyc = BEAT_CYCLES >> tempo;
`else
      beat_cyc = BEAT_CYCLES;
`endif
      play_cyc = (int'(rom_dur) + 1) * beat_cyc - GAP_CYCLES;
      if (play_cyc < 1) begin
         play_cyc = 1;
      end
      play_last_calc = CNT_W'(play_cyc - 1);
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg + CNT_W'(1);
      play_last_next = play_last_reg;
      step_idx_next  = step_idx_reg;
      note_out_next  = note_out_reg;
      done_next      = 1'b0;
      load_play      = 1'b0;

      if (stop) begin
         // Abort from anywhere: silent, rewound, and no completion pulse
         state_next    = IDLE;
         cnt_next      = '0;
         step_idx_next = '0;
         note_out_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_next      = '0;
               step_idx_next = '0;
               note_out_next = '0;
               if (start) begin
                  load_play = 1'b1;
               end
            end

            PLAY: begin
               if (cnt_reg == play_last_reg) begin
                  state_next    = GAP;
                  cnt_next      = '0;
                  note_out_next = '0;
               end
            end

            GAP: begin
               note_out_next = '0;
               if (cnt_reg == GAP_LAST) begin
                  if (step_idx_reg != LAST_STEP) begin
                     step_idx_next = step_idx_reg + STEP_W'(1);
                     load_play     = 1'b1;
                  end else if (loop_en) begin
                     step_idx_next = '0;
                     load_play     = 1'b1;
                  end else begin
                     state_next    = IDLE;
                     cnt_next      = '0;
                     step_idx_next = '0;
                     done_next     = 1'b1;
                  end
               end
            end

            default: begin
               state_next    = IDLE;
               cnt_next      = '0;
               step_idx_next = '0;
               note_out_next = '0;
            end
         endcase

         // Common PLAY entry: load note (or silence for a rest) and its length
         if (load_play) begin
            state_next     = PLAY;
            cnt_next       = '0;
            play_last_next = play_last_calc;
            note_out_next  = rom_rest ? 8'h00 : onehot8(rom_note);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         play_last_reg <= '0;
         step_idx_reg  <= '0;
         note_out_reg  <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         play_last_reg <= play_last_next;
         step_idx_reg  <= step_idx_next;
         note_out_reg  <= note_out_next;
         done_reg      <= done_next;
      end
   end

   assign note_out = note_out_reg;
   assign step_idx = step_idx_reg;
   assign done     = done_reg;
   assign busy     = (state_reg == PLAY) || (state_reg == GAP);

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//   Directed sequence with randomized poke/stop points, checked against a
//   song-timeline model built from the melody's note/beat table.
//   BEAT_CYCLES=20, GAP_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;

   localparam int BEAT = 20;
   localparam int GAP  = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       loop_en;
`ifdef MELODY_SEQ_TEMPO_EN
   logic [1:0] tempo;
`endif
   logic [7:0] note_out;
   logic [3:0] step_idx;
   logic       busy;
   logic       done;

   int total;
   int bad;

   // Song description: note index, rest flag, length in beats
   int m_note  [16];
   bit m_rest  [16];
   int m_beats [16];
   int song_cyc;

   melody_sequencer #(
      .BEAT_CYCLES (BEAT),
      .GAP_CYCLES  (GAP),
      .SONG_LEN    (16)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
`ifdef MELODY_SEQ_TEMPO_EN
      .tempo    (tempo),
`endif
      .note_out (note_out),
      .step_idx (step_idx),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected note/step at cycle offset k (0 = first audible cycle) of one song
   function automatic void model_at(input int k, output logic [7:0] n, output logic [3:0] s);
      int t;
      int len;
      t = k;
      n = 8'h00;
      s = 4'h0;
      for (int i = 0; i < 16; i++) begin
         len = m_beats[i] * BEAT;
         if (t < len) begin
            s = 4'(i);
            if (t < len - GAP && !m_rest[i]) n = 8'd1 << m_note[i];
            return;
         end
         t -= len;
      end
   endfunction

   // mode 0: single song; 1: looping; 2: start held high (restarts after done)
   task automatic check_at(input string tag, input int k, input int mode);
      logic [7:0] en;
      logic [3:0] es;
      logic       eb;
      logic       ed;
      int         kk;
      kk = k;
      if (mode == 1) kk = k % song_cyc;
      if (mode == 2 && k > song_cyc) kk = k - song_cyc - 1;
      if (kk < song_cyc) begin
         model_at(kk, en, es);
         eb = 1'b1;
         ed = 1'b0;
      end else begin
         en = 8'h00;
         es = 4'h0;
         eb = 1'b0;
         ed = (kk == song_cyc);
      end
      chk($sformatf("%s.k%0d.note", tag, k), 32'(note_out), 32'(en));
      chk($sformatf("%s.k%0d.step", tag, k), 32'(step_idx), 32'(es));
      chk($sformatf("%s.k%0d.busy", tag, k), 32'(busy),     32'(eb));
      chk($sformatf("%s.k%0d.done", tag, k), 32'(done),     32'(ed));
   endtask

   // Called at the negedge after start was sampled; walks offsets 0..cycles-1
   // and returns at the negedge of offset 'cycles'.
   task automatic run_song(input string tag, input int cycles, input int mode,
                           input int poke_at, input logic le_final);
      for (int k = 0; k < cycles; k++) begin
         check_at(tag, k, mode);
         start   = (mode == 2) || (k == poke_at);
         loop_en = (k < 300) ? 1'($urandom_range(1, 0)) : le_final;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".note"}, 32'(note_out), 32'h0);
      chk({tag, ".step"}, 32'(step_idx), 32'h0);
      chk({tag, ".busy"}, 32'(busy),     32'h0);
      chk({tag, ".done"}, 32'(done),     32'h0);
   endtask

   initial begin
      int poke;
      int r;
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_en = 1'b0;
`ifdef MELODY_SEQ_TEMPO_EN
      tempo   = 2'd0;
`endif
      for (int i = 0; i < 16; i++) begin
         m_rest[i]  = 1'b0;
         m_beats[i] = 1;
         m_note[i]  = (i < 8) ? i : 15 - i;
      end
      m_beats[7] = 2;
      m_rest[8]  = 1'b1;
      song_cyc = 0;
      for (int i = 0; i < 16; i++) song_cyc += m_beats[i] * BEAT;

      // Reset state
      @(negedge clk);
      check_idle("reset");
      $display("reset checked");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("idle");

      // Full song, no loop, with a stray start pulse while busy
      poke = $urandom_range(300, 5);
      $display("single song, stray start at offset %0d", poke);
      start = 1'b1;
      @(negedge clk);
      run_song("single", song_cyc + 6, 0, poke, 1'b0);

      // Looping: passes through step 15 GAP into step 0 with no done
      $display("looping song, two passes");
      start = 1'b1;
      @(negedge clk);
      run_song("loop", 2 * song_cyc + 20, 1, -1, 1'b1);
      stop = 1'b1;
      @(negedge clk);
      stop    = 1'b0;
      loop_en = 1'b0;
      check_idle("loop.stop");

      // Stop in the middle of step 5 PLAY
      $display("stop at step 5 offset 103");
      start = 1'b1;
      @(negedge clk);
      run_song("stop5", 103, 0, -1, 1'b0);
      check_at("stop5", 103, 0);
      stop = 1'b1;
      @(negedge clk);
      check_idle("stop5.after");
      stop = 1'b0;
      @(negedge clk);
      check_idle("stop5.idle");

      // Stop at a random point, including the final GAP
      r = $urandom_range(song_cyc - 1, 1);
      $display("stop at random offset %0d", r);
      start = 1'b1;
      @(negedge clk);
      run_song("stopr", r, 0, -1, 1'b0);
      stop = 1'b1;
      @(negedge clk);
      check_idle("stopr.after");
      stop = 1'b0;
      @(negedge clk);
      check_idle("stopr.idle");

      // start and stop together in IDLE: stop wins
      $display("start+stop together");
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      check_idle("both.1");
      start = 1'b0;
      stop  = 1'b0;
      @(negedge clk);
      check_idle("both.2");

      // Asynchronous reset in the GAP of step 5
      $display("async reset in step 5 gap");
      start = 1'b1;
      @(negedge clk);
      run_song("arst", 117, 0, -1, 1'b0);
      check_at("arst", 117, 0);
      #2 rst_n = 1'b0;
      #2 check_idle("arst.async");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("arst.idle");

      // start held high: new song begins the cycle after done
      $display("start held through done");
      start = 1'b1;
      @(negedge clk);
      run_song("hold", song_cyc + 12, 2, -1, 1'b0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check_idle("hold.stop");

`ifdef MELODY_SEQ_TEMPO_EN
      // tempo=2: beat 5, so a one-beat step plays 1 cycle then 4 of gap
      $display("tempo x4");
      tempo = 2'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("tempo.k0.note", 32'(note_out), 32'h01);
      @(negedge clk);
      chk("tempo.k1.note", 32'(note_out), 32'h00);
      repeat (4) @(negedge clk);
      chk("tempo.k5.note", 32'(note_out), 32'h02);
      chk("tempo.k5.step", 32'(step_idx), 32'h1);
      stop = 1'b1;
      @(negedge clk);
      stop  = 1'b0;
      tempo = 2'd0;
      check_idle("tempo.stop");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
